// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the MIPS multi-cycle control sequencer.
// Used by mips_inst_class and mips_multicycle_ctrl.
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
    } state_e;

    typedef enum logic [2:0] {
        CL_LOAD, CL_STORE, CL_RTYPE, CL_ITYPE, CL_BRANCH, CL_JUMP, CL_JREG, CL_INVALID
    } iclass_e;

    typedef enum logic [1:0] {
        SZ_WORD, SZ_HALF, SZ_BYTE
    } size_e;

    localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [1:0] PC_SRC_REG    = 2'd3;

    localparam logic [1:0] REG_DEST_RT = 2'd0;
    localparam logic [1:0] REG_DEST_RD = 2'd1;
    localparam logic [1:0] REG_DEST_RA = 2'd2;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;

    function automatic logic [3:0] lane_enables(input size_e sz, input logic [1:0] lo);
        case (sz)
            SZ_HALF: lane_enables = lo[1] ? 4'b1100 : 4'b0011;
            SZ_BYTE: lane_enables = 4'b0001 << lo;
            default: lane_enables = 4'b1111;
        endcase
    endfunction

    function automatic logic misaligned(input size_e sz, input logic [1:0] lo);
        case (sz)
            SZ_WORD: misaligned = (lo != 2'b00);
            SZ_HALF: misaligned = lo[0];
            default: misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_inst_class.sv
// Combinational instruction classifier: opcode/funct -> class, access size
// and link flag (jal/jalr write a return address).
module mips_inst_class
    import mips_ctrl_pkg::*;
(
    input  logic [31:0] i_inst,
    output iclass_e     o_class,
    output size_e       o_size,
    output logic        o_link
);

    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic       w_unused_fields;

    assign w_op            = i_inst[31:26];
    assign w_funct         = i_inst[5:0];
    assign w_unused_fields = ^i_inst[25:6];

    always_comb begin
        o_class = CL_INVALID;
        o_size  = SZ_WORD;
        o_link  = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                if (w_funct == FN_JR) begin
                    o_class = CL_JREG;
                end else if (w_funct == FN_JALR) begin
                    o_class = CL_JREG;
                    o_link  = 1'b1;
                end else begin
                    o_class = CL_RTYPE;
                end
            end
            OP_J:   o_class = CL_JUMP;
            OP_JAL: begin
                o_class = CL_JUMP;
                o_link  = 1'b1;
            end
            OP_BEQ, OP_BNE: o_class = CL_BRANCH;
            OP_LW:          o_class = CL_LOAD;
            OP_LH, OP_LHU: begin
                o_class = CL_LOAD;
                o_size  = SZ_HALF;
            end
            OP_LB, OP_LBU: begin
                o_class = CL_LOAD;
                o_size  = SZ_BYTE;
            end
            OP_SW:          o_class = CL_STORE;
            OP_SH: begin
                o_class = CL_STORE;
                o_size  = SZ_HALF;
            end
            OP_SB: begin
                o_class = CL_STORE;
                o_size  = SZ_BYTE;
            end
            default: begin
                // 0x08..0x0F: addi, addiu, slti, sltiu, andi, ori, xori, lui
                if (w_op[5:3] == 3'b001) o_class = CL_ITYPE;
            end
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT with Avalon
// waitrequest handshake. Define MEM_TIMEOUT_EN to fault on stuck transfers.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int ADDR_LSB_W     = 2,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           inst,
    input  logic                  waitrequest,
    input  logic [ADDR_LSB_W-1:0] addr_lo,
    input  logic                  branch_taken,
    input  logic                  pc_zero,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [3:0]            byteenable,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic [1:0]            pc_src,
    output logic                  alu_src,
    output logic [1:0]            reg_dest,
    output logic                  reg_write,
    output logic                  mem_to_reg,
    output logic                  active,
    output logic                  fault
);

    if ((2 ** TIMEOUT_W) <= TIMEOUT_CYCLES) begin : g_timeout_w_check
        $error("TIMEOUT_W too narrow for TIMEOUT_CYCLES");
    end

    state_e     r_state;
    iclass_e    r_class;
    size_e      r_size;
    logic       r_link;
    logic       r_mem_read;
    logic       r_mem_write;
    logic [3:0] r_be;
    logic       r_active;
    logic       r_fault;

    iclass_e    w_class;
    size_e      w_size;
    logic       w_link;
    logic [1:0] w_lo;
    logic       w_timeout;

    assign w_lo = 2'(addr_lo);

    mips_inst_class u_cls (
        .i_inst (inst),
        .o_class(w_class),
        .o_size (w_size),
        .o_link (w_link)
    );

`ifdef MEM_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] r_to_cnt;
    assign w_timeout = (r_to_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // Strobes are flops so waitrequest never reaches them combinationally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_FETCH;
            r_class     <= CL_INVALID;
            r_size      <= SZ_WORD;
            r_link      <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_be        <= 4'b1111;
            r_active    <= 1'b1;
            r_fault     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            r_to_cnt    <= '0;
`endif
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (!r_mem_read) begin
                        // First FETCH cycle decides halt before any read goes out.
                        if (pc_zero) begin
                            r_state  <= ST_HALT;
                            r_active <= 1'b0;
                        end else begin
                            r_mem_read <= 1'b1;
`ifdef MEM_TIMEOUT_EN
                            r_to_cnt   <= '0;
`endif
                        end
                    end else if (!waitrequest) begin
                        r_mem_read <= 1'b0;
                        r_state    <= ST_DECODE;
                    end else if (w_timeout) begin
                        r_mem_read <= 1'b0;
                        r_fault    <= 1'b1;
                        r_active   <= 1'b0;
                        r_state    <= ST_HALT;
                    end else begin
`ifdef MEM_TIMEOUT_EN
                        r_to_cnt <= r_to_cnt + 1'b1;
`endif
                    end
                end
                ST_DECODE: begin
                    r_class <= w_class;
                    r_size  <= w_size;
                    r_link  <= w_link;
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    case (r_class)
                        CL_LOAD, CL_STORE: begin
                            if (misaligned(r_size, w_lo)) begin
                                r_fault  <= 1'b1;
                                r_active <= 1'b0;
                                r_state  <= ST_HALT;
                            end else begin
                                r_be        <= lane_enables(r_size, w_lo);
                                r_mem_read  <= (r_class == CL_LOAD);
                                r_mem_write <= (r_class == CL_STORE);
                                r_state     <= ST_MEM;
`ifdef MEM_TIMEOUT_EN
                                r_to_cnt    <= '0;
`endif
                            end
                        end
                        CL_RTYPE, CL_ITYPE: r_state <= ST_WB;
                        CL_INVALID: begin
                            r_fault  <= 1'b1;
                            r_active <= 1'b0;
                            r_state  <= ST_HALT;
                        end
                        default: r_state <= ST_FETCH;
                    endcase
                end
                ST_MEM: begin
                    if (!waitrequest || w_timeout) begin
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_be        <= 4'b1111;
                    end
                    if (!waitrequest) begin
                        r_state <= (r_class == CL_LOAD) ? ST_WB : ST_FETCH;
                    end else if (w_timeout) begin
                        r_fault  <= 1'b1;
                        r_active <= 1'b0;
                        r_state  <= ST_HALT;
                    end else begin
`ifdef MEM_TIMEOUT_EN
                        r_to_cnt <= r_to_cnt + 1'b1;
`endif
                    end
                end
                ST_WB:   r_state <= ST_FETCH;
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_HALT;
            endcase
        end
    end

    always_comb begin
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SRC_SEQ;
        alu_src    = 1'b0;
        reg_dest   = REG_DEST_RD;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        case (r_state)
            ST_FETCH: ir_write = r_mem_read & ~waitrequest;
            ST_EXEC: begin
                alu_src = (r_class == CL_LOAD) || (r_class == CL_STORE) || (r_class == CL_ITYPE);
                case (r_class)
                    CL_BRANCH: begin
                        pc_write = branch_taken;
                        pc_src   = PC_SRC_BRANCH;
                    end
                    CL_JUMP: begin
                        pc_write  = 1'b1;
                        pc_src    = PC_SRC_JUMP;
                        reg_write = r_link;
                        if (r_link) reg_dest = REG_DEST_RA;
                    end
                    CL_JREG: begin
                        pc_write  = 1'b1;
                        pc_src    = PC_SRC_REG;
                        reg_write = r_link;
                    end
                    default: ;
                endcase
            end
            ST_MEM: pc_write = (r_class == CL_STORE) & ~waitrequest;
            ST_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (r_class == CL_LOAD);
                reg_dest   = (r_class == CL_RTYPE) ? REG_DEST_RD : REG_DEST_RT;
                pc_write   = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem_read   = r_mem_read;
    assign mem_write  = r_mem_write;
    assign byteenable = r_be;
    assign active     = r_active;
    assign fault      = r_fault;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: per-instruction cycle plans derived from the
// instruction-class rules, directed scenarios plus random instruction streams.
module tb_mips_multicycle_ctrl;

`ifdef MEM_TIMEOUT_EN
    localparam int TO_CYC = 4;
`else
    localparam int TO_CYC = 255;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] inst = '0;
    logic        waitrequest = 1'b0;
    logic [1:0]  addr_lo = '0;
    logic        branch_taken = 1'b0;
    logic        pc_zero = 1'b0;
    logic        mem_read, mem_write, ir_write, pc_write, alu_src, reg_write, mem_to_reg, active, fault;
    logic [3:0]  byteenable;
    logic [1:0]  pc_src, reg_dest;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.ADDR_LSB_W(2), .TIMEOUT_CYCLES(TO_CYC), .TIMEOUT_W(8)) dut (
        .clk(clk), .reset(reset), .inst(inst), .waitrequest(waitrequest), .addr_lo(addr_lo),
        .branch_taken(branch_taken), .pc_zero(pc_zero), .mem_read(mem_read), .mem_write(mem_write),
        .byteenable(byteenable), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_src(alu_src), .reg_dest(reg_dest), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .active(active), .fault(fault)
    );

    typedef struct packed {
        logic       rd, wr;
        logic [3:0] be;
        logic       irw, pcw;
        logic [1:0] pcs;
        logic       alus;
        logic [1:0] rdst;
        logic       rw, m2r, act, flt;
    } outs_t;

    typedef struct {
        logic        wr, pz, bt;
        logic [31:0] ins;
        logic [1:0]  lo;
        outs_t       exp;
        int          ph;
    } step_t;

    step_t plan[$];
    int total = 0;
    int bad = 0;
    int n_rd, n_wr, n_rw;

    localparam logic [31:0] NOP = 32'h0000_0000;

    function automatic outs_t idle(input logic act, input logic flt);
        outs_t o;
        o = '0;
        o.be = 4'b1111;
        o.rdst = 2'd1;
        o.act = act;
        o.flt = flt;
        return o;
    endfunction

    function automatic outs_t observe();
        outs_t o;
        o.rd = mem_read; o.wr = mem_write; o.be = byteenable; o.irw = ir_write;
        o.pcw = pc_write; o.pcs = pc_src; o.alus = alu_src; o.rdst = reg_dest;
        o.rw = reg_write; o.m2r = mem_to_reg; o.act = active; o.flt = fault;
        return o;
    endfunction

    task automatic push(input logic wr, input logic pz, input logic bt, input logic [31:0] ins,
                        input logic [1:0] lo, input outs_t e, input int ph);
        step_t s;
        s.wr = wr; s.pz = pz; s.bt = bt; s.ins = ins; s.lo = lo; s.exp = e; s.ph = ph;
        plan.push_back(s);
    endtask

    // Expected cycle sequence for one instruction, starting at its first FETCH cycle.
    task automatic plan_inst(input logic [31:0] ins, input int fw, input int mw,
                             input logic [1:0] lo, input logic bt, output bit halted);
        logic [5:0] op, fn;
        bit ld, st, rt, it, br, jmp, jal, jr, jalr, inv, mis;
        int sz;
        logic [3:0] be;
        outs_t o;
        op = ins[31:26]; fn = ins[5:0];
        {ld, st, rt, it, br, jmp, jal, jr, jalr, inv} = '0;
        sz = 0;
        case (op)
            6'h23: ld = 1;
            6'h21, 6'h25: begin ld = 1; sz = 1; end
            6'h20, 6'h24: begin ld = 1; sz = 2; end
            6'h2B: st = 1;
            6'h29: begin st = 1; sz = 1; end
            6'h28: begin st = 1; sz = 2; end
            6'h00: begin
                if (fn == 6'h08) jr = 1;
                else if (fn == 6'h09) jalr = 1;
                else rt = 1;
            end
            6'h02: jmp = 1;
            6'h03: begin jmp = 1; jal = 1; end
            6'h04, 6'h05: br = 1;
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: it = 1;
            default: inv = 1;
        endcase
        be  = (sz == 0) ? 4'b1111 : (sz == 1) ? (lo[1] ? 4'b1100 : 4'b0011) : (4'b0001 << lo);
        mis = (ld || st) && ((sz == 0 && lo != 2'b00) || (sz == 1 && lo[0]));
        halted = 1'b0;

        push($urandom, 1'b0, $urandom, ins, lo, idle(1, 0), 0);
        for (int i = 0; i < fw; i++) begin
            o = idle(1, 0); o.rd = 1;
            push(1'b1, $urandom, $urandom, ins, lo, o, 1);
        end
        o = idle(1, 0); o.rd = 1; o.irw = 1;
        push(1'b0, $urandom, $urandom, ins, lo, o, 2);
        push($urandom, $urandom, $urandom, ins, lo, idle(1, 0), 3);

        o = idle(1, 0);
        o.alus = ld | st | it;
        if (br) begin o.pcw = bt; o.pcs = 2'd1; end
        if (jmp) begin o.pcw = 1; o.pcs = 2'd2; o.rw = jal; if (jal) o.rdst = 2'd2; end
        if (jr || jalr) begin o.pcw = 1; o.pcs = 2'd3; o.rw = jalr; end
        push($urandom, $urandom, bt, ins, lo, o, 4);
        if (inv || mis) begin halted = 1'b1; return; end
        if (br || jmp || jr || jalr) return;

        if (ld || st) begin
            for (int i = 0; i <= mw; i++) begin
                o = idle(1, 0); o.rd = ld; o.wr = st; o.be = be;
                o.pcw = st && (i == mw);
                push((i == mw) ? 1'b0 : 1'b1, $urandom, $urandom, ins, lo, o, 5);
            end
        end
        if (ld || rt || it) begin
            o = idle(1, 0); o.rw = 1; o.m2r = ld; o.rdst = rt ? 2'd1 : 2'd0; o.pcw = 1;
            push($urandom, $urandom, $urandom, ins, lo, o, 6);
        end
    endtask

    task automatic plan_halt(input int n, input logic flt);
        for (int i = 0; i < n; i++) push($urandom, $urandom, $urandom, NOP, 2'b00, idle(0, flt), 7);
    endtask

    task automatic run_plan(input string name);
        step_t s;
        outs_t obs;
        n_rd = 0; n_wr = 0; n_rw = 0;
        while (plan.size() > 0) begin
            s = plan.pop_front();
            @(negedge clk);
            waitrequest = s.wr; pc_zero = s.pz; branch_taken = s.bt; inst = s.ins; addr_lo = s.lo;
            #1;
            obs = observe();
            total++;
            if (obs !== s.exp) begin
                bad++;
                $display("FAIL %s phase=%0d got=%h expected=%h", name, s.ph, obs, s.exp);
            end
            n_rd += int'(mem_read); n_wr += int'(mem_write); n_rw += int'(reg_write);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        #1 reset = 1'b1;
    endtask

    task automatic test_reset();
        bit h;
        @(posedge clk);
        #1 reset = 1'b0; waitrequest = 1'b0; pc_zero = 1'b0;
        #1;
        total++;
        if (observe() !== idle(1, 0)) begin
            bad++; $display("FAIL reset_state got=%h expected=%h", observe(), idle(1, 0));
        end
        @(posedge clk);
        #1;
        total++;
        if (observe() !== idle(1, 0)) begin
            bad++; $display("FAIL reset_held got=%h expected=%h", observe(), idle(1, 0));
        end
        reset = 1'b1;
        plan_inst(NOP, 0, 0, 2'b00, 1'b0, h);
        run_plan("reset_first_fetch");
    endtask

    task automatic test_reset_mid_mem();
        bit h;
        do_reset();
        plan_inst(32'h8C22_0004, 0, 3, 2'b00, 1'b0, h);
        while (plan.size() > 5) void'(plan.pop_back());
        run_plan("mid_mem_pre");
        reset = 1'b0;
        #1;
        total++;
        if (observe() !== idle(1, 0)) begin
            bad++; $display("FAIL mid_mem_reset got=%h expected=%h", observe(), idle(1, 0));
        end
        @(posedge clk);
        #1 reset = 1'b1;
        plan_inst(NOP, 1, 0, 2'b00, 1'b0, h);
        run_plan("mid_mem_refetch");
    endtask

    task automatic test_lw();
        bit h;
        do_reset();
        plan_inst(32'h8C22_0004, 0, 3, 2'b00, 1'b0, h);
        run_plan("lw");
        total++;
        if (n_rd != 5) begin bad++; $display("FAIL lw_read_cycles got=%0d expected=5", n_rd); end
        total++;
        if (n_rw != 1) begin bad++; $display("FAIL lw_regwrite_cycles got=%0d expected=1", n_rw); end
        plan_inst(NOP, 0, 0, 2'b00, 1'b0, h);
        run_plan("lw_next");
    endtask

    task automatic test_sb();
        bit h;
        do_reset();
        plan_inst(32'hA022_0002, 1, 0, 2'b10, 1'b0, h);
        run_plan("sb");
        total++;
        if (n_wr != 1) begin bad++; $display("FAIL sb_write_cycles got=%0d expected=1", n_wr); end
        total++;
        if (n_rw != 0) begin bad++; $display("FAIL sb_regwrite got=%0d expected=0", n_rw); end
    endtask

    task automatic test_jalr();
        bit h;
        do_reset();
        plan_inst(32'h0080_F809, 0, 0, 2'b00, 1'b0, h);
        run_plan("jalr");
        total++;
        if (n_rw != 1) begin bad++; $display("FAIL jalr_regwrite got=%0d expected=1", n_rw); end
        plan_inst(NOP, 0, 0, 2'b00, 1'b0, h);
        run_plan("jalr_next");
    endtask

    task automatic test_halt_jr();
        bit h;
        do_reset();
        plan_inst(32'h0000_0008, 0, 0, 2'b00, 1'b0, h);
        push(1'b0, 1'b1, 1'b0, NOP, 2'b00, idle(1, 0), 0);
        plan_halt(6, 1'b0);
        run_plan("jr_halt");
        total++;
        if (n_rd != 1) begin bad++; $display("FAIL jr_halt_reads got=%0d expected=1", n_rd); end
    endtask

    task automatic test_faults();
        bit h;
        do_reset();
        plan_inst(32'hFC00_0000, 0, 0, 2'b00, 1'b0, h);
        if (h) plan_halt(4, 1'b1);
        run_plan("invalid");
        total++;
        if (fault !== 1'b1) begin bad++; $display("FAIL invalid_fault got=%b expected=1", fault); end
        do_reset();
        plan_inst(32'h8422_0001, 0, 0, 2'b01, 1'b0, h);
        if (h) plan_halt(4, 1'b1);
        run_plan("misaligned_lh");
        do_reset();
        plan_inst(32'hAC22_0002, 0, 0, 2'b10, 1'b0, h);
        if (h) plan_halt(4, 1'b1);
        run_plan("misaligned_sw");
        total++;
        if (n_wr != 0) begin bad++; $display("FAIL misaligned_sw_strobe got=%0d expected=0", n_wr); end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        outs_t o;
        do_reset();
        push(1'b1, 1'b0, 1'b0, NOP, 2'b00, idle(1, 0), 0);
        o = idle(1, 0); o.rd = 1;
        for (int i = 0; i < 4; i++) push(1'b1, 1'b0, 1'b0, NOP, 2'b00, o, 1);
        for (int i = 0; i < 4; i++) push(1'b1, 1'b0, 1'b0, NOP, 2'b00, idle(0, 1), 7);
        run_plan("fetch_timeout");
        total++;
        if (n_rd != 4) begin bad++; $display("FAIL timeout_read_cycles got=%0d expected=4", n_rd); end
    endtask
`endif

    task automatic rand_inst(output logic [31:0] ins, output logic [1:0] lo);
        logic [5:0] op, fn;
        int k;
        k = $urandom_range(0, 9);
        fn = 6'($urandom);
        case (k)
            0, 8: case ($urandom_range(0, 4))
                0: op = 6'h23; 1: op = 6'h20; 2: op = 6'h24; 3: op = 6'h21; default: op = 6'h25;
            endcase
            1, 9: case ($urandom_range(0, 2))
                0: op = 6'h2B; 1: op = 6'h28; default: op = 6'h29;
            endcase
            2, 3: begin
                op = 6'h00;
                while (fn == 6'h08 || fn == 6'h09) fn = 6'($urandom);
            end
            4: op = 6'($urandom_range(8, 15));
            5: op = $urandom_range(0, 1) ? 6'h04 : 6'h05;
            6: op = $urandom_range(0, 1) ? 6'h02 : 6'h03;
            default: begin op = 6'h00; fn = $urandom_range(0, 1) ? 6'h08 : 6'h09; end
        endcase
        ins = {op, 20'($urandom), fn};
        lo = 2'($urandom);
        if (op == 6'h23 || op == 6'h2B) lo = 2'b00;
        if (op == 6'h21 || op == 6'h25 || op == 6'h29) lo[0] = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] ins;
        logic [1:0] lo;
        bit h;
        do_reset();
        for (int n = 0; n < 150; n++) begin
            rand_inst(ins, lo);
            plan_inst(ins, $urandom_range(0, 3), $urandom_range(0, 3), lo, 1'($urandom), h);
            run_plan("random");
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_mem();
        test_lw();
        test_sb();
        test_jalr();
        test_halt_jr();
        test_faults();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
